// File: rtl/syn_fifo.sv
// Single-clock FIFO with binary pointers, occupancy count and sticky error flags.
// Define SYN_FIFO_FWFT_EN for first-word fall-through reads; default is registered reads.
module syn_fifo #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    output logic                  walmost_full,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AFULL_CNT  = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = AEMPTY_THRESH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  empty;
    logic                  full;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags depend only on registered pointers/count, never on winc/rinc.
    assign empty         = (wptr == rptr);
    assign full          = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                           (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    assign wr_ok         = winc && !full;
    assign rd_ok         = rinc && !empty;
    assign wfull         = full;
    assign rempty        = empty;
    assign walmost_full  = (count >= AFULL_CNT);
    assign ralmost_empty = (count <= AEMPTY_CNT);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_ok) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + PTR_ONE;
                2'b01:   count <= count - PTR_ONE;
                default: count <= count;
            endcase
            if (winc && full) begin
                overflow <= 1'b1;
            end
            if (rinc && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef SYN_FIFO_FWFT_EN
    // Head word is presented directly; forced to zero while empty so reset shows 0.
    assign rdata = empty ? '0 : mem[rptr[ADDR_WIDTH-1:0]];
`else
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_ok) begin
            rdata_q <= mem[rptr[ADDR_WIDTH-1:0]];
        end
    end

    assign rdata = rdata_q;
`endif

endmodule
